// File: rtl/crypto_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crypto_link_pkg                                                            |
// | Shared constants, FSM states and LFSR step function for the C&C link.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package crypto_link_pkg;

    localparam int                LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'b1011_1000;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hFA;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } dec_state_e;

    // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_keystream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_keystream                                                             |
// | 8-bit keystream LFSR with load-over-step priority; shared by RX and TX.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lfsr_keystream
    import crypto_link_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] key
);

    // An all-zero state would lock the register, so a zero SEED falls back.
    localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? DEFAULT_SEED : SEED;

    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_d;

    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = load_val;
        end else if (step) begin
            s_d = lfsr_next(s_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= RESET_VAL;
        end else begin
            s_q <= s_d;
        end
    end

    assign key = s_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_stream_decryptor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lfsr_stream_decryptor                                                      |
// | Receive-side keystream XOR decipher with warm-up and seed resync.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lfsr_stream_decryptor
    import crypto_link_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
    parameter int unsigned       WARMUP = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LFSR_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LFSR_W-1:0] out_data,
    output logic              key_rdy,
    output logic [15:0]       byte_cnt
);

    localparam int unsigned       WCNT_W      = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WCNT_W-1:0] WCNT_INIT   = WCNT_W'(WARMUP);
    localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);
    localparam dec_state_e        START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    localparam logic [LFSR_W-1:0] GUARD_SEED  = (SEED == '0) ? DEFAULT_SEED : SEED;

    dec_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              out_valid_q, out_valid_d;
    logic [LFSR_W-1:0] out_data_q, out_data_d;
    logic              key_rdy_q, key_rdy_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;

    logic              w_warm_step;
    logic              w_in_ready;
    logic              w_accept;
    logic [LFSR_W-1:0] w_key;
    logic [LFSR_W-1:0] w_load_val;

    assign w_accept   = in_valid && w_in_ready;
    assign w_load_val = (seed_in == '0) ? GUARD_SEED : seed_in;

    lfsr_keystream #(
        .SEED (GUARD_SEED)
    ) u_keystream (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (w_warm_step || w_accept),
        .load     (seed_load),
        .load_val (w_load_val),
        .key      (w_key)
    );

    // Resync overrides both the warm-up countdown and any acceptance this cycle.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        w_warm_step = 1'b0;
        w_in_ready  = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                w_warm_step = 1'b1;
                wcnt_d      = wcnt_q - WCNT_ONE;
                if (wcnt_q == WCNT_ONE) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = !seed_load && (!out_valid_q || out_ready);
            end
            default: begin
                state_d = START_STATE;
            end
        endcase
        if (seed_load) begin
            state_d = START_STATE;
            wcnt_d  = WCNT_INIT;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        byte_cnt_d  = byte_cnt_q;
        key_rdy_d   = (state_d == ST_RUN);
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ w_key;
            byte_cnt_d  = byte_cnt_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (seed_load) begin
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= START_STATE;
            wcnt_q      <= WCNT_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            key_rdy_q   <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            key_rdy_q   <= key_rdy_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign key_rdy   = key_rdy_q;
    assign byte_cnt  = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream_decryptor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lfsr_stream_decryptor                                                   |
// | Scoreboard bench: instance 0 has no warm-up, instance 1 the default 11.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lfsr_stream_decryptor;

    logic            clk;
    logic [1:0]      rst_n;
    logic [1:0]      seed_load;
    logic [1:0][7:0] seed_in;
    logic [1:0]      in_valid;
    logic [1:0][7:0] in_data;
    logic [1:0]      out_ready;
    wire  [1:0]      in_ready;
    wire  [1:0]      out_valid;
    wire  [1:0][7:0] out_data;
    wire  [1:0]      key_rdy;
    wire  [1:0][15:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] expq0[$];
    logic [7:0] expq1[$];
    time t0;

    // Hand-computed keystream from FA: FA F4 E9 D3 A6 4C 99 33 66 CD 9A 35 6A D4
    lfsr_stream_decryptor #(.WARMUP(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .key_rdy(key_rdy[0]), .byte_cnt(byte_cnt[0])
    );

    lfsr_stream_decryptor dut1 (
        .clk(clk), .rst_n(rst_n[1]), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .key_rdy(key_rdy[1]), .byte_cnt(byte_cnt[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid[0] && out_ready[0]) begin
            if (expq0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_out: got %h expected no output", out_data[0]);
            end else begin
                chk("dut0_out_data", 16'(out_data[0]), 16'(expq0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid[1] && out_ready[1]) begin
            if (expq1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_out: got %h expected no output", out_data[1]);
            end else begin
                chk("dut1_out_data", 16'(out_data[1]), 16'(expq1.pop_front()));
            end
        end
    end

    // Called just after a rising edge; leaves in_valid high just after the accepting edge.
    task automatic send(input int d, input logic [7:0] data, input logic [7:0] exp);
        bit done = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                if (d == 0) expq0.push_back(exp);
                else        expq1.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout_dut%0d: got no in_ready expected ready within 40 cycles", d);
        end
    endtask

    task automatic idle(input int d);
        in_valid[d] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int d);
        rst_n[d] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[d] = 1'b1;
    endtask

    task automatic resync(input int d, input logic [7:0] seed);
        seed_load[d] = 1'b1;
        seed_in[d]   = seed;
        @(posedge clk);
        #1;
        seed_load[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst_n = 2'b00; seed_load = 2'b00; seed_in = '0;
        in_valid = 2'b00; in_data = '0; out_ready = 2'b11;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out_valid", 16'(out_valid[d]), 16'd0);
            chk("reset_key_rdy",   16'(key_rdy[d]),   16'd0);
            chk("reset_byte_cnt",  byte_cnt[d],       16'd0);
            chk("reset_out_data",  16'(out_data[d]),  16'd0);
        end

        // No warm-up: zeros expose the raw keystream at full rate.
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        t0 = $time;
        send(0, 8'h00, 8'hFA);
        send(0, 8'h00, 8'hF4);
        send(0, 8'h00, 8'hE9);
        send(0, 8'h00, 8'hD3);
        idle(0);
        chk("s1_burst_time", 16'($time - t0), 16'd40);
        chk("s1_byte_cnt", byte_cnt[0], 16'd4);
        cycles(2);

        pulse_reset(0);
        send(0, 8'hFA, 8'h00);
        send(0, 8'hF4, 8'h00);
        idle(0);
        chk("s2_byte_cnt", byte_cnt[0], 16'd2);
        cycles(2);

        // Backpressure must hold data and not advance the keystream.
        pulse_reset(0);
        out_ready[0] = 1'b0;
        send(0, 8'h00, 8'hFA);
        in_data[0] = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("s4_in_ready_held", 16'(in_ready[0]), 16'd0);
            chk("s4_out_valid_held", 16'(out_valid[0]), 16'd1);
            chk("s4_out_data_held", 16'(out_data[0]), 16'h00FA);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        send(0, 8'h00, 8'hF4);
        idle(0);
        cycles(2);
        chk("s4_byte_cnt", byte_cnt[0], 16'd2);

        // Zero seed with a concurrent byte: byte refused, seed falls back to FA.
        seed_load[0] = 1'b1; seed_in[0] = 8'h00;
        in_valid[0] = 1'b1; in_data[0] = 8'h55;
        @(negedge clk);
        chk("s5_in_ready_on_load", 16'(in_ready[0]), 16'd0);
        @(posedge clk); #1;
        seed_load[0] = 1'b0;
        in_valid[0] = 1'b0;
        chk("s5_byte_cnt_cleared", byte_cnt[0], 16'd0);
        send(0, 8'h00, 8'hFA);
        idle(0);
        cycles(2);

        resync(0, 8'h99);
        send(0, 8'h00, 8'h99);
        send(0, 8'h00, 8'h33);
        idle(0);
        cycles(2);

        // A pending byte from the old key drains after resync.
        out_ready[0] = 1'b0;
        send(0, 8'h0F, 8'h69);
        idle(0);
        resync(0, 8'h00);
        @(negedge clk);
        chk("s5_pending_valid", 16'(out_valid[0]), 16'd1);
        chk("s5_pending_data", 16'(out_data[0]), 16'h0069);
        chk("s5_pending_cnt", byte_cnt[0], 16'd0);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        send(0, 8'h00, 8'hFA);
        idle(0);
        cycles(2);
        chk("s5_cnt_after", byte_cnt[0], 16'd1);

        // Asynchronous reset discards the pending byte.
        out_ready[0] = 1'b0;
        send(0, 8'h00, 8'hF4);
        idle(0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("s6_dut0_async_valid", 16'(out_valid[0]), 16'd0);
        chk("s6_dut0_async_cnt", byte_cnt[0], 16'd0);
        if (expq0.size() > 0) void'(expq0.pop_back());
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        out_ready[0] = 1'b1;
        send(0, 8'h00, 8'hFA);
        idle(0);

        // Default warm-up: 11 idle cycles, then the 12th state.
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("s3_warm_in_ready", 16'(in_ready[1]), 16'd0);
            chk("s3_warm_key_rdy", 16'(key_rdy[1]), 16'd0);
        end
        @(negedge clk);
        chk("s3_run_in_ready", 16'(in_ready[1]), 16'd1);
        chk("s3_run_key_rdy", 16'(key_rdy[1]), 16'd1);
        @(posedge clk); #1;
        send(1, 8'h00, 8'h35);
        send(1, 8'h00, 8'h6A);
        idle(1);
        cycles(2);

        resync(1, 8'h00);
        chk("s3_resync_key_rdy", 16'(key_rdy[1]), 16'd0);
        send(1, 8'h00, 8'h35);
        idle(1);
        cycles(2);

        out_ready[1] = 1'b0;
        send(1, 8'h00, 8'h6A);
        idle(1);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("s6_dut1_async_valid", 16'(out_valid[1]), 16'd0);
        chk("s6_dut1_async_key_rdy", 16'(key_rdy[1]), 16'd0);
        chk("s6_dut1_async_cnt", byte_cnt[1], 16'd0);
        if (expq1.size() > 0) void'(expq1.pop_back());
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        out_ready[1] = 1'b1;
        send(1, 8'h00, 8'h35);
        idle(1);

        for (int i = 0; i < 20 && (expq0.size() != 0 || expq1.size() != 0); i++) cycles(1);
        cycles(2);
        chk("drain_q0", 16'(expq0.size()), 16'd0);
        chk("drain_q1", 16'(expq1.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
